mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Purpose: arbitrates fetch, load and store requests onto a single downstream memory port.
// Latency: grant sampled at N gives mc_valid_out at N+1; done pulse one cycle after mc_done_in.
// Backpressure: requests are levels held until their done pulse; rdy low freezes all state.
//
// Ports:
//   clk, rst (sync, active-high), rdy (global enable)
//   clear_flag_in    flush: aborts an in-flight fetch/load, blocks read grants while in IDLE
//   uart_full_in     blocks IO stores (sq_addr_in[17:16] == 2'b11)
//   if_*/lb_*/sq_*   fetch, load and store requesters with one-cycle done pulses
//   rd_data_out      read data, held until the next read completes
//   mc_*             downstream issue pulse, direction, address, length and data; completion and read data
// Build option: ARB_ROUND_ROBIN_EN alternates fetch/load priority (default is fixed fetch > load).
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear_flag_in,
    input  logic        uart_full_in,
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    output logic        if_done_out,
    input  logic        lb_req_in,
    input  logic [31:0] lb_addr_in,
    input  logic [1:0]  lb_len_in,
    output logic        lb_done_out,
    input  logic        sq_req_in,
    input  logic [31:0] sq_addr_in,
    input  logic [1:0]  sq_len_in,
    input  logic [31:0] sq_data_in,
    output logic        sq_done_out,
    output logic [31:0] rd_data_out,
    output logic        mc_valid_out,
    output logic        mc_write_out,
    output logic [31:0] mc_addr_out,
    output logic [1:0]  mc_len_out,
    output logic [31:0] mc_data_out,
    input  logic        mc_done_in,
    input  logic [31:0] mc_data_in
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;
    typedef enum logic [1:0] {OWN_IF, OWN_LB, OWN_SQ} owner_t;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_t     r_state;
    owner_t     r_owner;
    logic [2:0] r_starve_cnt;
    logic       r_io_gap;
`ifdef ARB_ROUND_ROBIN_EN
    logic       r_last_lb;
`endif

    logic w_sq_io;
    logic w_sq_elig;
    logic w_if_elig;
    logic w_lb_elig;
    logic w_rd_wait;
    logic w_starve;
    logic w_pick_lb;
    logic w_gnt_sq;
    logic w_gnt_if;
    logic w_gnt_lb;
    logic w_rd_abort;

    // IO stores wait out a full UART and the single cycle following a previous IO store's done.
    assign w_sq_io   = (sq_addr_in[17:16] == 2'b11);
    assign w_sq_elig = sq_req_in && !(w_sq_io && (uart_full_in || r_io_gap));
    assign w_if_elig = if_req_in && !clear_flag_in;
    assign w_lb_elig = lb_req_in && !clear_flag_in;
    assign w_rd_wait = if_req_in || lb_req_in;

    // Starvation only diverts the grant when a read can actually take it.
    assign w_starve  = (r_starve_cnt >= LIMIT) && (w_if_elig || w_lb_elig);
    assign w_gnt_sq  = w_sq_elig && !w_starve;

`ifdef ARB_ROUND_ROBIN_EN
    // The read served last time yields when both are eligible.
    assign w_pick_lb = w_lb_elig && (!w_if_elig || !r_last_lb);
`else
    assign w_pick_lb = w_lb_elig && !w_if_elig;
`endif
    assign w_gnt_lb  = !w_gnt_sq && w_pick_lb;
    assign w_gnt_if  = !w_gnt_sq && w_if_elig && !w_pick_lb;

    // A flush kills reads in flight; stores always run to completion.
    assign w_rd_abort = clear_flag_in && (r_owner != OWN_SQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_IF;
            r_starve_cnt <= '0;
            r_io_gap     <= 1'b0;
            if_done_out  <= 1'b0;
            lb_done_out  <= 1'b0;
            sq_done_out  <= 1'b0;
            mc_valid_out <= 1'b0;
            mc_write_out <= 1'b0;
            mc_addr_out  <= '0;
            mc_len_out   <= '0;
            mc_data_out  <= '0;
            rd_data_out  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_lb    <= 1'b1;
`endif
        end else if (rdy) begin
            if_done_out  <= 1'b0;
            lb_done_out  <= 1'b0;
            sq_done_out  <= 1'b0;
            mc_valid_out <= 1'b0;
            // mc_addr_out still holds the finished store's address during its done cycle.
            r_io_gap     <= sq_done_out && (mc_addr_out[17:16] == 2'b11);

            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_sq) begin
                        r_owner      <= OWN_SQ;
                        mc_addr_out  <= sq_addr_in;
                        mc_len_out   <= sq_len_in;
                        mc_data_out  <= sq_data_in;
                        mc_write_out <= 1'b1;
                        mc_valid_out <= 1'b1;
                        r_state      <= ST_ISSUE;
                        if (!w_rd_wait) begin
                            r_starve_cnt <= '0;
                        end else if (r_starve_cnt < LIMIT) begin
                            r_starve_cnt <= r_starve_cnt + 3'd1;
                        end
                    end else if (w_gnt_if) begin
                        r_owner      <= OWN_IF;
                        mc_addr_out  <= if_addr_in;
                        mc_len_out   <= 2'b11;
                        mc_data_out  <= '0;
                        mc_write_out <= 1'b0;
                        mc_valid_out <= 1'b1;
                        r_state      <= ST_ISSUE;
                        r_starve_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_lb    <= 1'b0;
`endif
                    end else if (w_gnt_lb) begin
                        r_owner      <= OWN_LB;
                        mc_addr_out  <= lb_addr_in;
                        mc_len_out   <= lb_len_in;
                        mc_data_out  <= '0;
                        mc_write_out <= 1'b0;
                        mc_valid_out <= 1'b1;
                        r_state      <= ST_ISSUE;
                        r_starve_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_lb    <= 1'b1;
`endif
                    end
                end
                ST_ISSUE: begin
                    r_state <= w_rd_abort ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    // Flush wins over a same-cycle completion.
                    if (w_rd_abort) begin
                        r_state <= ST_IDLE;
                    end else if (mc_done_in) begin
                        r_state <= ST_RESP;
                        if (r_owner == OWN_SQ) begin
                            sq_done_out <= 1'b1;
                        end else begin
                            rd_data_out <= mc_data_in;
                            if (r_owner == OWN_IF) begin
                                if_done_out <= 1'b1;
                            end else begin
                                lb_done_out <= 1'b1;
                            end
                        end
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed requests, an auto-responding downstream model,
// and a scoreboard monitor comparing every issue and done pulse against queued expectations.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        clear_flag_in = 1'b0;
    logic        uart_full_in = 1'b0;
    logic        if_req_in = 1'b0;
    logic [31:0] if_addr_in = '0;
    logic        if_done_out;
    logic        lb_req_in = 1'b0;
    logic [31:0] lb_addr_in = '0;
    logic [1:0]  lb_len_in = '0;
    logic        lb_done_out;
    logic        sq_req_in = 1'b0;
    logic [31:0] sq_addr_in = '0;
    logic [1:0]  sq_len_in = '0;
    logic [31:0] sq_data_in = '0;
    logic        sq_done_out;
    logic [31:0] rd_data_out;
    logic        mc_valid_out;
    logic        mc_write_out;
    logic [31:0] mc_addr_out;
    logic [1:0]  mc_len_out;
    logic [31:0] mc_data_out;
    logic        mc_done_in = 1'b0;
    logic [31:0] mc_data_in = '0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .clear_flag_in(clear_flag_in), .uart_full_in(uart_full_in),
        .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_done_out(if_done_out),
        .lb_req_in(lb_req_in), .lb_addr_in(lb_addr_in), .lb_len_in(lb_len_in), .lb_done_out(lb_done_out),
        .sq_req_in(sq_req_in), .sq_addr_in(sq_addr_in), .sq_len_in(sq_len_in), .sq_data_in(sq_data_in),
        .sq_done_out(sq_done_out), .rd_data_out(rd_data_out),
        .mc_valid_out(mc_valid_out), .mc_write_out(mc_write_out), .mc_addr_out(mc_addr_out),
        .mc_len_out(mc_len_out), .mc_data_out(mc_data_out),
        .mc_done_in(mc_done_in), .mc_data_in(mc_data_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  len;
        logic        wr;
        logic [31:0] data;
        int          c;
    } iss_t;

    typedef struct {
        logic [2:0]  kind;   // {if, lb, sq}
        logic [31:0] rd;
        int          c;
    } dn_t;

    localparam logic [2:0] K_IF = 3'b100;
    localparam logic [2:0] K_LB = 3'b010;
    localparam logic [2:0] K_SQ = 3'b001;

    iss_t q_iss[$];
    dn_t  q_dn[$];
    int   checks = 0;
    int   errors = 0;
    logic [31:0] last_rd = '0;

    int          resp_delay = 1;
    logic [31:0] resp_data = '0;
    logic        resp_abort = 1'b0;

    task automatic push_iss(input logic [31:0] a, input logic [1:0] l, input logic w,
                            input logic [31:0] d, input int c);
        iss_t e;
        e.addr = a; e.len = l; e.wr = w; e.data = d; e.c = c;
        q_iss.push_back(e);
    endtask

    task automatic push_dn(input logic [2:0] k, input logic [31:0] rd, input int c);
        dn_t e;
        e.kind = k; e.rd = rd; e.c = c;
        q_dn.push_back(e);
    endtask

    task automatic tmo(input string s);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", s);
    endtask

    task automatic chk(input string s, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", s, act, exp);
        end
    endtask

    // Downstream model: completes each issued command resp_delay cycles later unless aborted.
    always begin : responder
        int  n;
        logic ab;
        @(negedge clk);
        if (mc_valid_out && !rst) begin
            n  = 0;
            ab = 1'b0;
            while (n < resp_delay && !ab) begin
                @(negedge clk);
                n++;
                if (resp_abort) ab = 1'b1;
            end
            if (!ab) begin
                mc_done_in = 1'b1;
                mc_data_in = resp_data;
                @(negedge clk);
                mc_done_in = 1'b0;
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin : monitor
        iss_t ei;
        dn_t  ed;
        logic [2:0] k;
        logic ok;
        if (!rst) begin
            if (mc_valid_out) begin
                checks++;
                if (q_iss.size() == 0) begin
                    errors++;
                    $display("FAIL issue_unexpected: got addr=%h wr=%0b cyc=%0d want no issue", mc_addr_out, mc_write_out, cyc);
                end else begin
                    ei = q_iss.pop_front();
                    ok = (mc_addr_out === ei.addr) && (mc_len_out === ei.len) && (mc_write_out === ei.wr)
                         && (!ei.wr || mc_data_out === ei.data) && (ei.c < 0 || cyc == ei.c);
                    if (!ok) begin
                        errors++;
                        $display("FAIL issue: got addr=%h len=%0d wr=%0b data=%h cyc=%0d want addr=%h len=%0d wr=%0b data=%h cyc=%0d",
                                 mc_addr_out, mc_len_out, mc_write_out, mc_data_out, cyc,
                                 ei.addr, ei.len, ei.wr, ei.data, ei.c);
                    end
                end
            end
            k = {if_done_out, lb_done_out, sq_done_out};
            if (k != 3'b000) begin
                checks++;
                if (q_dn.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: got kind=%b cyc=%0d want no done", k, cyc);
                end else begin
                    ed = q_dn.pop_front();
                    ok = (k === ed.kind) && (rd_data_out === ed.rd) && (ed.c < 0 || cyc == ed.c);
                    if (!ok) begin
                        errors++;
                        $display("FAIL done: got kind=%b rd=%h cyc=%0d want kind=%b rd=%h cyc=%0d",
                                 k, rd_data_out, cyc, ed.kind, ed.rd, ed.c);
                    end
                end
            end
        end
    end

    // Drop each request after its given number of completions; return once all are low.
    task automatic run(input int if_n, input int lb_n, input int sq_n);
        int fi = 0;
        int fl = 0;
        int fs = 0;
        int t  = 0;
        while ((if_req_in || lb_req_in || sq_req_in) && t < 400) begin
            @(negedge clk);
            t++;
            if (if_done_out) begin fi++; if (fi >= if_n) if_req_in = 1'b0; end
            if (lb_done_out) begin fl++; if (fl >= lb_n) lb_req_in = 1'b0; end
            if (sq_done_out) begin fs++; if (fs >= sq_n) sq_req_in = 1'b0; end
        end
        if (t >= 400) tmo("run");
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_valid(input string s);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!mc_valid_out && t < 60);
        if (!mc_valid_out) tmo(s);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c;
        int t;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {25'd0, mc_valid_out, mc_write_out, if_done_out, lb_done_out, sq_done_out,
             mc_len_out, mc_addr_out, mc_data_out, rd_data_out}, 128'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single fetch: issue at N+1, done one cycle after mc_done_in
        resp_delay = 5; resp_data = 32'hDEADBEEF;
        c = cyc;
        if_addr_in = 32'h1000; if_req_in = 1'b1;
        push_iss(32'h1000, 2'b11, 1'b0, '0, c + 1);
        push_dn(K_IF, 32'hDEADBEEF, c + 7);
        last_rd = 32'hDEADBEEF;
        run(1, 0, 0);

        // rdy low freezes arbitration
        resp_delay = 2; resp_data = 32'h11112222;
        rdy = 1'b0; if_addr_in = 32'h2000; if_req_in = 1'b1;
        repeat (3) @(negedge clk);
        c = cyc; rdy = 1'b1;
        push_iss(32'h2000, 2'b11, 1'b0, '0, c + 1);
        push_dn(K_IF, 32'h11112222, -1);
        last_rd = 32'h11112222;
        run(1, 0, 0);

        // Reset during WAIT abandons the fetch and clears read data
        resp_delay = 8; if_addr_in = 32'h3000; if_req_in = 1'b1;
        push_iss(32'h3000, 2'b11, 1'b0, '0, -1);
        wait_valid("rst_wait_issue");
        repeat (2) @(negedge clk);
        rst = 1'b1; if_req_in = 1'b0; resp_abort = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; resp_abort = 1'b0;
        last_rd = '0;
        repeat (3) @(negedge clk);
        chk("rst_clears_rd_data", {96'd0, rd_data_out}, {96'd0, last_rd});

        // Starvation: 4 stores, fetch, store, then load
        resp_delay = 1; resp_data = 32'hCAFE0001;
        sq_addr_in = 32'h100; sq_len_in = 2'b11; sq_data_in = 32'hA5A50000;
        if_addr_in = 32'h4000; lb_addr_in = 32'h5000; lb_len_in = 2'b01;
        for (int i = 0; i < 4; i++) begin
            push_iss(32'h100, 2'b11, 1'b1, 32'hA5A50000, -1);
            push_dn(K_SQ, 32'h0, -1);
        end
        push_iss(32'h4000, 2'b11, 1'b0, '0, -1);
        push_dn(K_IF, 32'hCAFE0001, -1);
        push_iss(32'h100, 2'b11, 1'b1, 32'hA5A50000, -1);
        push_dn(K_SQ, 32'hCAFE0001, -1);
        push_iss(32'h5000, 2'b01, 1'b0, '0, -1);
        push_dn(K_LB, 32'hCAFE0001, -1);
        last_rd = 32'hCAFE0001;
        sq_req_in = 1'b1; if_req_in = 1'b1; lb_req_in = 1'b1;
        run(1, 1, 5);

        // Fetch and load held together for two completions each
        resp_data = 32'h12345678;
        if_addr_in = 32'hD000; lb_addr_in = 32'hE000; lb_len_in = 2'b11;
`ifdef ARB_ROUND_ROBIN_EN
        for (int i = 0; i < 2; i++) begin
            push_iss(32'hD000, 2'b11, 1'b0, '0, -1); push_dn(K_IF, 32'h12345678, -1);
            push_iss(32'hE000, 2'b11, 1'b0, '0, -1); push_dn(K_LB, 32'h12345678, -1);
        end
`else
        for (int i = 0; i < 2; i++) begin
            push_iss(32'hD000, 2'b11, 1'b0, '0, -1); push_dn(K_IF, 32'h12345678, -1);
        end
        for (int i = 0; i < 2; i++) begin
            push_iss(32'hE000, 2'b11, 1'b0, '0, -1); push_dn(K_LB, 32'h12345678, -1);
        end
`endif
        last_rd = 32'h12345678;
        if_req_in = 1'b1; lb_req_in = 1'b1;
        run(2, 2, 0);

        // IO store blocked by full UART; fetch goes first; back-to-back IO stores keep a one-cycle gap
        resp_delay = 1; resp_data = 32'h0BADF00D;
        uart_full_in = 1'b1;
        sq_addr_in = 32'h30000; sq_len_in = 2'b00; sq_data_in = 32'h55;
        if_addr_in = 32'h6000;
        push_iss(32'h6000, 2'b11, 1'b0, '0, -1);
        push_dn(K_IF, 32'h0BADF00D, -1);
        last_rd = 32'h0BADF00D;
        sq_req_in = 1'b1; if_req_in = 1'b1;
        t = 0;
        while (!if_done_out && t < 100) begin @(negedge clk); t++; end
        if (!if_done_out) tmo("io_fetch_done");
        if_req_in = 1'b0;
        repeat (4) @(negedge clk);
        c = cyc; uart_full_in = 1'b0;
        push_iss(32'h30000, 2'b00, 1'b1, 32'h55, c + 1);
        push_dn(K_SQ, 32'h0BADF00D, c + 3);
        push_iss(32'h30000, 2'b00, 1'b1, 32'h55, c + 6);
        push_dn(K_SQ, 32'h0BADF00D, c + 8);
        run(0, 0, 2);

        // Flush during load WAIT: no done, back to IDLE at once, store issues next
        resp_delay = 6; resp_data = 32'hFFFF0000;
        lb_addr_in = 32'h7000; lb_len_in = 2'b00; lb_req_in = 1'b1;
        push_iss(32'h7000, 2'b00, 1'b0, '0, -1);
        wait_valid("flush_load_issue");
        repeat (2) @(negedge clk);
        c = cyc;
        clear_flag_in = 1'b1; lb_req_in = 1'b0; resp_abort = 1'b1;
        sq_addr_in = 32'h9000; sq_len_in = 2'b11; sq_data_in = 32'h99; sq_req_in = 1'b1;
        push_iss(32'h9000, 2'b11, 1'b1, 32'h99, c + 2);
        push_dn(K_SQ, 32'h0BADF00D, -1);
        @(negedge clk);
        clear_flag_in = 1'b0;
        @(negedge clk);
        resp_abort = 1'b0;
        run(0, 0, 1);

        // Flush during store WAIT: store completes normally
        resp_delay = 4;
        sq_addr_in = 32'hA000; sq_len_in = 2'b01; sq_data_in = 32'h77; sq_req_in = 1'b1;
        push_iss(32'hA000, 2'b01, 1'b1, 32'h77, -1);
        push_dn(K_SQ, 32'h0BADF00D, -1);
        wait_valid("flush_store_issue");
        repeat (2) @(negedge clk);
        clear_flag_in = 1'b1;
        @(negedge clk);
        clear_flag_in = 1'b0;
        run(0, 0, 1);

        // Flush coinciding with mc_done_in on a fetch: no done, read data untouched
        resp_delay = 3; resp_data = 32'hFFFF0000;
        if_addr_in = 32'hB000; if_req_in = 1'b1;
        push_iss(32'hB000, 2'b11, 1'b0, '0, -1);
        wait_valid("flush_done_issue");
        repeat (3) @(negedge clk);
        clear_flag_in = 1'b1; if_req_in = 1'b0;
        @(negedge clk);
        clear_flag_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("flush_keeps_rd_data", {96'd0, rd_data_out}, {96'd0, last_rd});

        // Flush while IDLE delays a fetch grant by one cycle
        resp_delay = 1; resp_data = 32'h600DCAFE;
        c = cyc;
        clear_flag_in = 1'b1; if_addr_in = 32'hC000; if_req_in = 1'b1;
        push_iss(32'hC000, 2'b11, 1'b0, '0, c + 2);
        push_dn(K_IF, 32'h600DCAFE, c + 4);
        last_rd = 32'h600DCAFE;
        @(negedge clk);
        clear_flag_in = 1'b0;
        run(1, 0, 0);

        repeat (5) @(negedge clk);
        chk("issue_queue_drained", 128'(q_iss.size()), 128'd0);
        chk("done_queue_drained", 128'(q_dn.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
